// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: feeds one full_adder an operand bit pair per
// clock, LSB first, and assembles the WIDTH-bit result over WIDTH cycles.
//
// Handshake: start is sampled on every rising edge. It is accepted only in
// IDLE or DONE, where op_a/op_b/cin are captured on that same edge. Starts
// seen in RUN are dropped and not queued. busy is high for the WIDTH cycles
// of RUN. done is a one-cycle pulse in the cycle after the last RUN edge.
// sum/cout change only on that edge. busy and done are never high together.

// 1-bit full adder: s = a ^ b ^ d, c = majority(a, b, d)
module full_adder (
  output logic s,
  output logic c,
  input  logic a,
  input  logic b,
  input  logic d
);
  // Purely combinational sum and carry
  always_comb begin
    s = a ^ b ^ d;
    c = (a & b) | (a & d) | (b & d);
  end
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Current controller state; kept as a named signal so checkers can bind to it
  state_t           state_q;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_s;
  logic             fa_c;

  // The only adder in the design: one bit pair plus the running carry
  full_adder u_fa (
    .s (fa_s),
    .c (fa_c),
    .a (a_sh[0]),
    .b (b_sh[0]),
    .d (carry)
  );

  // Controller FSM and serial datapath, all registered
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
      a_sh    <= '0;
      b_sh    <= '0;
      res_sh  <= '0;
      carry   <= 1'b0;
      cnt     <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          done <= 1'b0;
          if (start) begin
            // Accept: capture operands, clear the bit counter and partial result
            a_sh    <= op_a;
            b_sh    <= op_b;
            carry   <= cin;
            cnt     <= '0;
            res_sh  <= '0;
            busy    <= 1'b1;
            state_q <= S_RUN;
          end else begin
            busy    <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        S_RUN: begin
          // One bit per edge: result fills from the MSB side as operands drain
          res_sh <= {fa_s, res_sh[WIDTH-1:1]};
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          carry  <= fa_c;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) begin
            // Final bit: publish the whole result at once, never a partial one
            sum     <= {fa_s, res_sh[WIDTH-1:1]};
            cout    <= fa_c;
            busy    <= 1'b0;
            done    <= 1'b1;
            state_q <= S_DONE;
          end
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Testbench for serial_add_ctrl (WIDTH=8): directed table, multi-cycle corner
// sequences, and a randomized back-to-back run against an arithmetic model.
module tb_serial_add_ctrl;

  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op_a  (op_a),
    .op_b  (op_b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  // ---------------- scoreboard state ----------------
  int           n_tests = 0;
  int           n_fail  = 0;
  logic [W:0]   exp_q[$];
  logic [W:0]   prev_res;
  logic [W:0]   mon_last;
  bit           mon_en = 1'b0;
  int           n_done = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic [W-1:0] s;
    logic         co;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  // Starts one addition from the current cycle and follows it to its done
  // cycle. Returns while done is high. hold keeps start asserted throughout;
  // glitch_at pulses a conflicting start in that RUN cycle.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                        input logic [W-1:0] es, input logic eco,
                        input bit hold, input int glitch_at);
    op_a  = a;
    op_b  = b;
    cin   = ci;
    start = 1'b1;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    // operands are free to change once accepted
    op_a = W'($urandom);
    op_b = W'($urandom);
    cin  = 1'($urandom);
    for (int k = 0; k < W; k++) begin
      check("busy_in_run", busy, 1);
      check("done_in_run", done, 0);
      check("sum_held_in_run", {cout, sum}, prev_res);
      if (k == glitch_at) begin
        start = 1'b1;
        op_a  = 8'hFF;
        op_b  = 8'hFF;
      end else if (!hold) begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
    check("done_pulse", done, 1);
    check("busy_at_done", busy, 0);
    check("result", {cout, sum}, {eco, es});
    prev_res = {eco, es};
  endtask

  // ---------------- monitor for the random phase ----------------
  always @(negedge clk) begin
    if (mon_en) begin
      check("busy_done_excl", busy & done, 0);
      if (done) begin
        n_done++;
        if (exp_q.size() == 0) begin
          check("rand_unexpected_done", 1, 0);
        end else begin
          mon_last = exp_q.pop_front();
          check("rand_result", {cout, sum}, mon_last);
        end
      end else begin
        check("rand_sum_stable", {cout, sum}, mon_last);
      end
    end
  end

  // Watchdog so the bench always terminates
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- main sequence ----------------
  initial begin
    bit         seen_done;
    logic [W:0] model;

    vecs[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1};
    vecs[3] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
    vecs[4] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[5] = '{8'h01, 8'h02, 1'b1, 8'h04, 1'b0};
    vecs[6] = '{8'h80, 8'h7F, 1'b1, 8'h00, 1'b1};

    rst   = 1'b1;
    start = 1'b0;
    op_a  = '0;
    op_b  = '0;
    cin   = 1'b0;
    prev_res = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_sum",  sum, 0);
    check("reset_cout", cout, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed table, back-to-back through the DONE cycle
    for (int i = 0; i < 7; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].s, vecs[i].co, 1'b0, -1);
    start = 1'b0;
    @(posedge clk); #1;
    check("done_one_cycle", done, 0);
    check("idle_busy", busy, 0);

    // Start during RUN is ignored; result holds while idle
    run_op(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, 3);
    start = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      check("idle_after_ignored_busy", busy, 0);
      check("idle_after_ignored_done", done, 0);
      check("idle_sum_hold", {cout, sum}, 9'h046);
    end

    // start held high: done pulses W+1 cycles apart
    run_op(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b1, -1);
    run_op(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, -1);
    start = 1'b0;
    @(posedge clk); #1;
    check("hold_end_done", done, 0);
    check("hold_end_busy", busy, 0);

    // Reset in the middle of RUN aborts with no done
    op_a  = 8'h55;
    op_b  = 8'hAA;
    cin   = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midreset_busy", busy, 0);
    check("midreset_done", done, 0);
    check("midreset_sum",  sum, 0);
    check("midreset_cout", cout, 0);
    prev_res  = '0;
    seen_done = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done || busy) seen_done = 1'b1;
    end
    check("midreset_no_activity", seen_done, 0);

    // rst and start on the same edge: start dropped
    op_a  = 8'h11;
    op_b  = 8'h22;
    start = 1'b1;
    rst   = 1'b1;
    @(posedge clk); #1;
    rst   = 1'b0;
    start = 1'b0;
    check("rst_start_busy", busy, 0);
    @(posedge clk); #1;
    check("rst_start_busy2", busy, 0);
    check("rst_start_done2", done, 0);
    check("rst_start_sum", {cout, sum}, 0);

    // Random back-to-back run with start held high
    mon_last = prev_res;
    mon_en   = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      op_a  = W'($urandom);
      op_b  = W'($urandom);
      cin   = 1'($urandom_range(0, 1));
      start = 1'b1;
      model = (W+1)'(op_a) + (W+1)'(op_b) + (W+1)'(cin);
      exp_q.push_back(model);
      @(posedge clk); #1;
      // operand changes after acceptance must not matter
      op_a = W'($urandom);
      op_b = W'($urandom);
      cin  = 1'($urandom);
      repeat (W) begin
        @(posedge clk); #1;
      end
    end
    start = 1'b0;
    repeat (W + 3) begin
      @(posedge clk); #1;
    end
    mon_en = 1'b0;
    check("rand_queue_empty", exp_q.size(), 0);
    check("rand_done_count", n_done, 1000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
Bit-serial adder controller. It sequences a single instance of the team's 1-bit full_adder over WIDTH clock cycles to add two WIDTH-bit operands plus a carry-in. Start/busy/done handshake toward the requester. It is the area-minimal alternative to a WIDTH-wide ripple adder, for datapaths where throughput is not critical.

Parameters:
WIDTH, 8, operand and result width in bits (legal range 2..32)

Ports:
clk  input  1  rising-edge clock; the only clock
rst  input  1  reset, synchronous, active-high; sampled on rising edge of clk
start  input  1  request to begin an addition; sampled on rising edge of clk
op_a  input  WIDTH  operand A; captured on accepted start
op_b  input  WIDTH  operand B; captured on accepted start
cin  input  1  carry-in; captured on accepted start
busy  output  1  high while an addition is in progress
done  output  1  one-cycle completion pulse
sum  output  WIDTH  registered result of the last completed addition
cout  output  1  registered carry-out of the last completed addition

Behaviour:
- Reset: when rst=1 at an edge, state goes to IDLE. busy=0, done=0, sum=0, cout=0, internal shift registers, carry and bit counter are cleared. rst overrides start and any operation in progress.
- Datapath: one full_adder instance, port order (s, c, a, b, d) = (sum bit, carry out, a bit, b bit, carry in).
  - Inputs: a_sh[0], b_sh[0] and the carry register.
  - No other adder logic is permitted.
- State IDLE: busy=0, done=0.
  - start=1 at an edge: latch op_a→a_sh, op_b→b_sh, cin→carry, clear counter and result shift register, go to RUN.
- State RUN: busy=1. Each edge:
  - Shift the full_adder s output into the result shift register MSB, with the register shifting right.
  - Shift a_sh and b_sh right by one.
  - Load carry with the full_adder c output.
  - Increment the counter.
  - On the edge where the counter reaches WIDTH-1, copy the completed result to sum and the final carry to cout, then go to DONE.
- State DONE: busy=0, done=1 for exactly one cycle.
  - start=1 at this edge: accepted exactly as from IDLE; go to RUN (back-to-back operation).
  - Otherwise go to IDLE.
- Latency: if start is accepted at edge E0, busy is high from E0 to E_WIDTH. done is high between E_WIDTH and E_WIDTH+1, and sum/cout are valid from E_WIDTH.
  - Throughput: one result every WIDTH+1 cycles when start is held high.
- start while in RUN: ignored. The in-flight operation is unaffected and the request is not queued.
- Operand stability: op_a, op_b and cin are only sampled on the accepting edge. Changes afterwards have no effect.
- sum/cout update only on the RUN→DONE transition. They hold their value through IDLE and through subsequent RUN cycles until the next completion. Partial results are never visible on sum.
- Arithmetic:
  - {cout, sum} = op_a + op_b + cin, modulo 2^(WIDTH+1).
  - Wrap-around: 0xFF+0x01 gives sum=0x00, cout=1 (WIDTH=8).
- Reset mid-operation: the operation is aborted, no done pulse is generated, and outputs return to reset values.
- start and rst high on the same edge: rst wins. The start is dropped.
- done and busy are never high in the same cycle.

Test Plan:
1. Reset, then start with op_a=0x00, op_b=0x00, cin=0 (WIDTH=8) → busy high for 8 cycles; done pulses once at the 8th edge after start; sum=0x00, cout=0.
2. Start with op_a=0xFF, op_b=0x01, cin=0 → sum=0x00, cout=1. Then op_a=0xA5, op_b=0x5A, cin=1 → sum=0x00, cout=1. Then 0x7F+0x01, cin=0 → sum=0x80, cout=0.
3. Start with 0x12+0x34, then pulse start again with 0xFF+0xFF at cycle 3 of RUN → the second request is ignored; sum=0x46, cout=0 at done; sum stays 0x46 through the following idle cycles.
4. Hold start=1 continuously with operands 0x0F+0x01 then 0x80+0x80 (second set applied in the DONE cycle) → done pulses 9 cycles apart; sum=0x10/cout=0, then sum=0x00/cout=1.
5. Start 0x55+0xAA, assert rst at RUN cycle 3 → busy=0, done=0, sum=0x00, cout=0 after the reset edge, and no done pulse follows.
6. Scoreboard: 1000 random op_a, op_b, cin triples, back-to-back → every done matches op_a+op_b+cin; busy&done is never 1; sum is stable between done pulses.
